control_sequencer: RTL and testbench

Hardwired control unit that drives the datapath control lines, in place of a bench-side step sequence. After each instruction fetch it decodes the instruction register and steps through control states T0..T6, issuing one set of control signals per clock. It covers fetch plus all register-register ALU, multiply/divide and unary instructions. It sits beside the datapath and is wired bit-for-bit onto its control ports.

---
 rtl/control_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch, then a decode-driven walk through T3..T6
// that issues one set of datapath strobes per clock.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        mem_rdy,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        INout,
    output logic        Cout,
    output logic        Yout,
    output logic        MARout,
    output logic [12:0] alu_op,
    output logic        run
);

    typedef enum logic [2:0] {
        T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_HALT = 5'd27;

    state_t      state_reg, state_next;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic        is_tri, is_md, is_un, is_halt;
    logic [12:0] alu_sel;
    logic        unused_ir;

    assign op        = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_reg_decode
            assign ra_oh[gi] = (ra == 4'(gi));
            assign rb_oh[gi] = (rb == 4'(gi));
            assign rc_oh[gi] = (rc == 4'(gi));
        end
    endgenerate

    assign is_tri  = (op >= OP_ADD) && (op <= OP_SHL);
    assign is_md   = (op == OP_MUL) || (op == OP_DIV);
    assign is_un   = (op == OP_NEG) || (op == OP_NOT);
    assign is_halt = (op == OP_HALT);

    always_comb begin
        alu_sel = '0;
        case (op)
            OP_AND:  alu_sel[12] = 1'b1;
            OP_OR:   alu_sel[11] = 1'b1;
            OP_ADD:  alu_sel[10] = 1'b1;
            OP_SUB:  alu_sel[9]  = 1'b1;
            OP_MUL:  alu_sel[8]  = 1'b1;
            OP_DIV:  alu_sel[7]  = 1'b1;
            OP_SHR:  alu_sel[6]  = 1'b1;
            OP_SHRA: alu_sel[5]  = 1'b1;
            OP_SHL:  alu_sel[4]  = 1'b1;
            OP_ROR:  alu_sel[3]  = 1'b1;
            OP_ROL:  alu_sel[2]  = 1'b1;
            OP_NEG:  alu_sel[1]  = 1'b1;
            OP_NOT:  alu_sel[0]  = 1'b1;
            default: alu_sel     = '0;
        endcase
    end

    // Unexpected opcodes past T3 (IR disturbed mid-instruction) fall back to fetch.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            T0:      state_next = T1;
            T1:      state_next = mem_rdy ? T2 : T1;
            T2:      state_next = T3;
            T3: begin
                if (is_tri || is_md || is_un) state_next = T4;
                else if (is_halt)             state_next = HALT;
                else                          state_next = T0;
            end
            T4:      state_next = (is_tri || is_md) ? T5 : T0;
            T5:      state_next = is_md ? T6 : T0;
            T6:      state_next = T0;
            HALT:    state_next = HALT;
            default: state_next = T0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= T0;
        else        state_reg <= state_next;
    end

    always_comb begin
        Rout     = '0;
        Rin      = '0;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        alu_op   = '0;
        run      = (state_reg != HALT);
        case (state_reg)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                PCin  = 1'b1;
            end
            T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_tri) begin
                    Rout = rb_oh;
                    Yin  = 1'b1;
                end else if (is_md) begin
                    Rout = ra_oh;
                    Yin  = 1'b1;
                end else if (is_un) begin
                    Rout   = rb_oh;
                    alu_op = alu_sel;
                    Zin    = 1'b1;
                end
            end
            T4: begin
                if (is_tri) begin
                    Rout   = rc_oh;
                    alu_op = alu_sel;
                    Zin    = 1'b1;
                end else if (is_md) begin
                    Rout   = rb_oh;
                    alu_op = alu_sel;
                    Zin    = 1'b1;
                end else if (is_un) begin
                    Zlowout = 1'b1;
                    Rin     = ra_oh;
                end
            end
            T5: begin
                if (is_tri) begin
                    Zlowout = 1'b1;
                    Rin     = ra_oh;
                end else if (is_md) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign HIout  = 1'b0;
    assign LOout  = 1'b0;
    assign INout  = 1'b0;
    assign Cout   = 1'b0;
    assign Yout   = 1'b0;
    assign MARout = 1'b0;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected strobe sequences from an
// opcode-class model, plus literal sequences for a few known instructions.
module tb_control_sequencer;

    typedef struct packed {
        logic        run;
        logic [15:0] rout;
        logic [15:0] rin;
        logic        pcout, pcin, incpc, marin, mdrin, mdrout, read, irin;
        logic        yin, zin, zhighout, zlowout, hiin, loin;
        logic [5:0]  tied;
        logic [12:0] alu;
    } ovec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR;
    logic        mem_rdy;
    logic [15:0] Rout, Rin;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin;
    logic Zhighout, Zlowout, HIin, LOin, HIout, LOout, INout, Cout, Yout, MARout;
    logic [12:0] alu_op;
    logic        run;

    ovec_t dut_v;
    ovec_t exp_q[$];
    logic  rdy_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cycle  = 0;
    string tag;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .reset(reset), .IR(IR), .mem_rdy(mem_rdy),
        .Rout(Rout), .Rin(Rin), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .INout(INout),
        .Cout(Cout), .Yout(Yout), .MARout(MARout), .alu_op(alu_op), .run(run)
    );

    assign dut_v = {run, Rout, Rin, PCout, PCin, IncPC, MARin, MDRin, MDRout,
                    Read, IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin,
                    {HIout, LOout, INout, Cout, Yout, MARout}, alu_op};

    function automatic ovec_t blank();
        ovec_t v = '0;
        v.run = 1'b1;
        return v;
    endfunction

    function automatic ovec_t v_t0();
        ovec_t v = blank();
        v.pcout = 1; v.marin = 1; v.incpc = 1; v.pcin = 1;
        return v;
    endfunction

    function automatic ovec_t v_t1();
        ovec_t v = blank();
        v.read = 1; v.mdrin = 1;
        return v;
    endfunction

    function automatic ovec_t v_t2();
        ovec_t v = blank();
        v.mdrout = 1; v.irin = 1;
        return v;
    endfunction

    // ALU select as listed in the interface: bit 12 AND down to bit 0 NOT.
    function automatic logic [12:0] alu_vec(input int op);
        int pos;
        case (op)
            5:  pos = 12; 6:  pos = 11; 3:  pos = 10; 4:  pos = 9;
            16: pos = 8;  15: pos = 7;  9:  pos = 6;  10: pos = 5;
            11: pos = 4;  7:  pos = 3;  8:  pos = 2;  17: pos = 1;
            18: pos = 0;  default: pos = -1;
        endcase
        return (pos < 0) ? 13'd0 : 13'(1 << pos);
    endfunction

    task automatic push(input ovec_t v, input logic rdy);
        exp_q.push_back(v);
        rdy_q.push_back(rdy);
    endtask

    task automatic push_fetch(input int wait_cycles);
        push(v_t0(), 1'($urandom_range(1)));
        for (int i = 0; i < wait_cycles; i++) push(v_t1(), 1'b0);
        push(v_t1(), 1'b1);
        push(v_t2(), 1'($urandom_range(1)));
    endtask

    // Model: expected per-cycle outputs for one instruction from its opcode class.
    task automatic build_instr(input logic [31:0] ir, input int wait_cycles);
        int op = int'(ir[31:27]);
        int ra = int'(ir[26:23]);
        int rb = int'(ir[22:19]);
        int rc = int'(ir[18:15]);
        ovec_t v;
        push_fetch(wait_cycles);
        if (op >= 3 && op <= 11) begin
            v = blank(); v.rout = 16'(1 << rb); v.yin = 1; push(v, 1'($urandom_range(1)));
            v = blank(); v.rout = 16'(1 << rc); v.alu = alu_vec(op); v.zin = 1; push(v, 1'($urandom_range(1)));
            v = blank(); v.zlowout = 1; v.rin = 16'(1 << ra); push(v, 1'($urandom_range(1)));
        end else if (op == 15 || op == 16) begin
            v = blank(); v.rout = 16'(1 << ra); v.yin = 1; push(v, 1'($urandom_range(1)));
            v = blank(); v.rout = 16'(1 << rb); v.alu = alu_vec(op); v.zin = 1; push(v, 1'($urandom_range(1)));
            v = blank(); v.zlowout = 1; v.loin = 1; push(v, 1'($urandom_range(1)));
            v = blank(); v.zhighout = 1; v.hiin = 1; push(v, 1'($urandom_range(1)));
        end else if (op == 17 || op == 18) begin
            v = blank(); v.rout = 16'(1 << rb); v.alu = alu_vec(op); v.zin = 1; push(v, 1'($urandom_range(1)));
            v = blank(); v.zlowout = 1; v.rin = 16'(1 << ra); push(v, 1'($urandom_range(1)));
        end else if (op == 27) begin
            push(blank(), 1'($urandom_range(1)));
            for (int i = 0; i < 22; i++) push(ovec_t'(0), 1'($urandom_range(1)));
        end else begin
            push(blank(), 1'($urandom_range(1)));
        end
    endtask

    task automatic check(input string name, input ovec_t exp);
        checks++;
        if (dut_v !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h required %h", name, cycle, dut_v, exp);
        end
    endtask

    // Drives mem_rdy and checks every queued cycle; stops after max_n cycles.
    task automatic run_cycles(input int max_n);
        int n = 0;
        while (exp_q.size() > 0 && n < max_n) begin
            ovec_t e = exp_q.pop_front();
            mem_rdy = rdy_q.pop_front();
            @(negedge clk);
            check($sformatf("%s step%0d", tag, n), e);
            n++;
            cycle++;
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        rdy_q.delete();
    endtask

    task automatic pulse_reset(input string name);
        #3 reset = 1'b0;
        #1 check(name, v_t0());
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] r = $urandom();
        int sel = $urandom_range(5);
        int op;
        if (sel == 0) begin
            do op = $urandom_range(31); while ((op >= 3 && op <= 11) ||
                (op >= 15 && op <= 18) || op == 27);
        end else if (sel <= 2) op = $urandom_range(11, 3);
        else if (sel == 3)     op = $urandom_range(16, 15);
        else                   op = $urandom_range(18, 17);
        return {5'(op), r[26:0]};
    endfunction

    initial begin
        ovec_t v;
        reset = 1'b0;
        IR = 32'h0;
        mem_rdy = 1'b0;
        tag = "reset";
        @(negedge clk); check("reset_hold0", v_t0());
        @(negedge clk); check("reset_hold1", v_t0());
        @(posedge clk); #1 reset = 1'b1;

        // ror R4,R3,R7 with literal expectations
        tag = "ror_lit"; IR = 32'h3A1B8000;
        push_fetch(0);
        v = blank(); v.rout = 16'h0008; v.yin = 1; push(v, 1);
        v = blank(); v.rout = 16'h0080; v.alu = 13'h0008; v.zin = 1; push(v, 1);
        v = blank(); v.zlowout = 1; v.rin = 16'h0010; push(v, 1);
        push(v_t0(), 1);
        run_cycles(7);

        // mul R2,R5 literal (run_cycles re-enters at T1 for this fetch)
        tag = "mul_lit"; IR = 32'h81280000;
        push(v_t1(), 1); push(v_t2(), 1);
        v = blank(); v.rout = 16'h0004; v.yin = 1; push(v, 0);
        v = blank(); v.rout = 16'h0020; v.alu = 13'h0100; v.zin = 1; push(v, 0);
        v = blank(); v.zlowout = 1; v.loin = 1; push(v, 0);
        v = blank(); v.zhighout = 1; v.hiin = 1; push(v, 0);
        run_cycles(6);

        // neg R2,R3 with three wait cycles in T1
        tag = "neg_wait"; IR = 32'h89180000;
        push(v_t0(), 0);
        for (int i = 0; i < 3; i++) push(v_t1(), 0);
        push(v_t1(), 1); push(v_t2(), 0);
        v = blank(); v.rout = 16'h0008; v.alu = 13'h0002; v.zin = 1; push(v, 0);
        v = blank(); v.zlowout = 1; v.rin = 16'h0004; push(v, 0);
        run_cycles(8);

        // abandon an instruction in T4
        tag = "abort_t4"; IR = {5'd4, 27'h2A5F123};
        build_instr(IR, 0);
        run_cycles(5);
        pulse_reset("reset_mid_t4");

        for (int k = 0; k < 40; k++) begin
            IR = rand_ir();
            tag = $sformatf("rnd%0d_op%0d", k, IR[31:27]);
            build_instr(IR, $urandom_range(3));
            run_cycles(1000);
        end

        tag = "halt"; IR = {5'd27, 27'h5555555};
        build_instr(IR, 1);
        run_cycles(1000);
        pulse_reset("reset_from_halt");
        tag = "after_halt"; IR = 32'h89180000;
        build_instr(IR, 0);
        run_cycles(1000);
        tag = "after_halt_t0";
        push(v_t0(), 0);
        run_cycles(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
